// File: rtl/scene_mem.sv
// scene_mem: scene storage with vertex/triangle/instance memories, descriptor tables, wipe and instance lookup.
// SCENE_MEM_BOUNDS_CHECK_EN rejects buffer headers that overrun their RAM and discards their data beats.
module scene_mem #(
  parameter int MAX_VERT = 8192,
  parameter int MAX_TRI = 8192,
  parameter int MAX_INST = 256,
  parameter int MAX_VERT_BUF = 256,
  parameter int MAX_TRI_BUF = 256,
  parameter int CNT_W = 9,
  parameter int VTX_W = 108,
  parameter int TRI_W = 24,
  parameter int TRANS_W = 384,
  parameter int PAYLOAD_W = 384,
  parameter int ID_W = 8,
  localparam int VADDR_W = $clog2(MAX_VERT),
  localparam int TADDR_W = $clog2(MAX_TRI),
  localparam int IID_W = $clog2(MAX_INST),
  localparam int VID_W = $clog2(MAX_VERT_BUF),
  localparam int TID_W = $clog2(MAX_TRI_BUF),
  localparam int BASE_W = (VADDR_W > TADDR_W) ? VADDR_W : TADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [ID_W-1:0]      cmd_id,
  input  logic [BASE_W-1:0]    cmd_base,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic [VID_W-1:0]     cmd_vid,
  input  logic [TID_W-1:0]     cmd_tid,
  input  logic [PAYLOAD_W-1:0] cmd_data,
  output logic                 cmd_err,
  output logic                 busy,
  output logic [IID_W:0]       inst_count,
  input  logic [VADDR_W-1:0]   vert_rd_addr,
  output logic [VTX_W-1:0]     vert_rd_data,
  input  logic [TADDR_W-1:0]   tri_rd_addr,
  output logic [TRI_W-1:0]     tri_rd_data,
  input  logic                 inst_rd_req,
  input  logic [IID_W-1:0]     inst_rd_id,
  output logic                 inst_rd_valid,
  output logic                 inst_rd_hit,
  output logic [TRANS_W-1:0]   inst_rd_transform,
  output logic [VADDR_W-1:0]   inst_rd_vert_base,
  output logic [CNT_W-1:0]     inst_rd_vert_count,
  output logic [TADDR_W-1:0]   inst_rd_tri_base,
  output logic [CNT_W-1:0]     inst_rd_tri_count
);
  localparam int WL1 = (MAX_INST > MAX_VERT_BUF) ? MAX_INST : MAX_VERT_BUF;
  localparam int WIPE_LEN = (WL1 > MAX_TRI_BUF) ? WL1 : MAX_TRI_BUF;
  localparam int WIDX_W = $clog2(WIPE_LEN);
  localparam logic [2:0] S_WIPE = 3'd0, S_IDLE = 3'd1, S_VERT = 3'd2, S_TRI = 3'd3, S_DISC = 3'd4;
  localparam logic [3:0] OP_WIPE = 4'd0, OP_VHDR = 4'd1, OP_THDR = 4'd2, OP_CREATE = 4'd3, OP_UPDATE = 4'd4, OP_DELETE = 4'd5;
  logic [VTX_W-1:0] vert_ram [MAX_VERT];
  logic [TRI_W-1:0] tri_ram [MAX_TRI];
  logic [TRANS_W-1:0] inst_tr [MAX_INST];
  logic [VID_W-1:0] inst_vid [MAX_INST];
  logic [TID_W-1:0] inst_tid [MAX_INST];
  logic [VADDR_W-1:0] vd_base [MAX_VERT_BUF];
  logic [CNT_W-1:0] vd_cnt [MAX_VERT_BUF];
  logic [TADDR_W-1:0] td_base [MAX_TRI_BUF];
  logic [CNT_W-1:0] td_cnt [MAX_TRI_BUF];
  logic [2:0] state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [BASE_W-1:0] ptr_q, ptr_d, d_base;
  logic [CNT_W-1:0] rem_q, rem_d, d_cnt;
  logic [IID_W:0] cnt_q, cnt_d;
  logic [MAX_INST-1:0] valid_q, valid_d;
  logic err_q, err_d, ready_q, ready_d, busy_q, busy_d;
  logic beat, oob, vd_we, td_we, tr_we, ids_we, vram_we, tram_we;
  logic [VID_W-1:0] vd_addr;
  logic [TID_W-1:0] td_addr;
  logic [IID_W-1:0] iid;
  logic [VTX_W-1:0] vrd_q;
  logic [TRI_W-1:0] trd_q;
  logic s1_req_q, s1_hit_q, o_valid_q, o_hit_q;
  logic [TRANS_W-1:0] s1_tr_q, o_tr_q;
  logic [VID_W-1:0] s1_vid_q;
  logic [TID_W-1:0] s1_tid_q;
  logic [VADDR_W-1:0] o_vb_q;
  logic [TADDR_W-1:0] o_tb_q;
  logic [CNT_W-1:0] o_vc_q, o_tc_q;
  assign beat = cmd_valid && ready_q;
  assign iid = cmd_id[IID_W-1:0];
  always_comb begin
    state_d = state_q;
    widx_d = widx_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    err_d = 1'b0;
    oob = 1'b0;
    vd_we = 1'b0;
    td_we = 1'b0;
    vd_addr = cmd_id[VID_W-1:0];
    td_addr = cmd_id[TID_W-1:0];
    d_base = cmd_base;
    d_cnt = cmd_count;
    tr_we = 1'b0;
    ids_we = 1'b0;
    vram_we = 1'b0;
    tram_we = 1'b0;
    if (state_q == S_WIPE) begin
      if (32'(widx_q) < MAX_INST) valid_d[widx_q[IID_W-1:0]] = 1'b0;
      vd_we = 32'(widx_q) < MAX_VERT_BUF;
      td_we = 32'(widx_q) < MAX_TRI_BUF;
      vd_addr = widx_q[VID_W-1:0];
      td_addr = widx_q[TID_W-1:0];
      d_base = '0;
      d_cnt = '0;
      widx_d = widx_q + 1'b1;
      if (32'(widx_q) == WIPE_LEN - 1) state_d = S_IDLE;
    end else if (beat && state_q == S_IDLE) begin
      case (cmd_op)
        OP_WIPE: begin
          state_d = S_WIPE;
          widx_d = '0;
          cnt_d = '0;
        end
        OP_VHDR, OP_THDR: begin
`ifdef SCENE_MEM_BOUNDS_CHECK_EN
          oob = 32'(cmd_base) + 32'(cmd_count) > ((cmd_op == OP_VHDR) ? 32'(MAX_VERT) : 32'(MAX_TRI));
`else
          oob = 1'b0;
`endif
          vd_we = !oob && cmd_op == OP_VHDR;
          td_we = !oob && cmd_op == OP_THDR;
          err_d = oob;
          ptr_d = cmd_base;
          rem_d = cmd_count;
          if (cmd_count != '0) state_d = oob ? S_DISC : (cmd_op == OP_VHDR) ? S_VERT : S_TRI;
        end
        OP_CREATE: begin
          tr_we = 1'b1;
          ids_we = 1'b1;
          valid_d[iid] = 1'b1;
          cnt_d = cnt_q + (IID_W+1)'(!valid_q[iid]);
        end
        OP_UPDATE: begin
          tr_we = valid_q[iid];
          err_d = !valid_q[iid];
        end
        OP_DELETE: begin
          valid_d[iid] = 1'b0;
          cnt_d = cnt_q - (IID_W+1)'(valid_q[iid]);
        end
        default: err_d = 1'b1;
      endcase
    end else if (beat) begin
      vram_we = state_q == S_VERT;
      tram_we = state_q == S_TRI;
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
      if (rem_q == CNT_W'(1)) state_d = S_IDLE;
    end
    ready_d = state_d != S_WIPE;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WIPE;
      widx_q <= '0;
      ptr_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      valid_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
  // RAMs and tables carry no reset; only the wipe clears the tables
  always_ff @(posedge clk) begin
    if (vram_we) vert_ram[ptr_q[VADDR_W-1:0]] <= cmd_data[VTX_W-1:0];
    if (tram_we) tri_ram[ptr_q[TADDR_W-1:0]] <= cmd_data[TRI_W-1:0];
    if (vd_we) begin
      vd_base[vd_addr] <= d_base[VADDR_W-1:0];
      vd_cnt[vd_addr] <= d_cnt;
    end
    if (td_we) begin
      td_base[td_addr] <= d_base[TADDR_W-1:0];
      td_cnt[td_addr] <= d_cnt;
    end
    if (tr_we) inst_tr[iid] <= cmd_data[TRANS_W-1:0];
    if (ids_we) begin
      inst_vid[iid] <= cmd_vid;
      inst_tid[iid] <= cmd_tid;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vrd_q <= '0;
      trd_q <= '0;
      s1_req_q <= 1'b0;
      s1_hit_q <= 1'b0;
      s1_tr_q <= '0;
      s1_vid_q <= '0;
      s1_tid_q <= '0;
      o_valid_q <= 1'b0;
      o_hit_q <= 1'b0;
      o_tr_q <= '0;
      o_vb_q <= '0;
      o_vc_q <= '0;
      o_tb_q <= '0;
      o_tc_q <= '0;
    end else begin
      vrd_q <= vert_ram[vert_rd_addr];
      trd_q <= tri_ram[tri_rd_addr];
      s1_req_q <= inst_rd_req;
      s1_hit_q <= inst_rd_req && valid_q[inst_rd_id];
      s1_tr_q <= inst_tr[inst_rd_id];
      s1_vid_q <= inst_vid[inst_rd_id];
      s1_tid_q <= inst_tid[inst_rd_id];
      o_valid_q <= s1_req_q;
      o_hit_q <= s1_hit_q;
      o_tr_q <= s1_hit_q ? s1_tr_q : '0;
      o_vb_q <= s1_hit_q ? vd_base[s1_vid_q] : '0;
      o_vc_q <= s1_hit_q ? vd_cnt[s1_vid_q] : '0;
      o_tb_q <= s1_hit_q ? td_base[s1_tid_q] : '0;
      o_tc_q <= s1_hit_q ? td_cnt[s1_tid_q] : '0;
    end
  end
  assign cmd_ready = ready_q;
  assign cmd_err = err_q;
  assign busy = busy_q;
  assign inst_count = cnt_q;
  assign vert_rd_data = vrd_q;
  assign tri_rd_data = trd_q;
  assign inst_rd_valid = o_valid_q;
  assign inst_rd_hit = o_hit_q;
  assign inst_rd_transform = o_tr_q;
  assign inst_rd_vert_base = o_vb_q;
  assign inst_rd_vert_count = o_vc_q;
  assign inst_rd_tri_base = o_tb_q;
  assign inst_rd_tri_count = o_tc_q;
endmodule

// File: tb/tb_scene_mem.sv
// tb_scene_mem: randomized bench for scene_mem against an array-based scene model.
module tb_scene_mem;
  localparam int MV = 8192, MT = 8192;
  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_err, busy;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_id = '0, cmd_vid = '0, cmd_tid = '0, inst_rd_id = '0;
  logic [12:0] cmd_base = '0, vert_rd_addr = '0, tri_rd_addr = '0, inst_rd_vert_base, inst_rd_tri_base;
  logic [8:0] cmd_count = '0, inst_count, inst_rd_vert_count, inst_rd_tri_count;
  logic [383:0] cmd_data = '0, inst_rd_transform;
  logic [107:0] vert_rd_data;
  logic [23:0] tri_rd_data;
  logic inst_rd_req = 1'b0, inst_rd_valid, inst_rd_hit;
  int total = 0, bad = 0;
  logic [107:0] m_vram [MV];
  logic [23:0] m_tram [MT];
  logic [12:0] m_vb [256], m_tb [256];
  logic [8:0] m_vc [256], m_tc [256];
  logic m_val [256];
  logic [383:0] m_tr [256];
  logic [7:0] m_vid [256], m_tid [256];
  int m_cnt;
  always #5 clk = ~clk;
  scene_mem dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_id(cmd_id), .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_vid(cmd_vid), .cmd_tid(cmd_tid),
    .cmd_data(cmd_data), .cmd_err(cmd_err), .busy(busy), .inst_count(inst_count),
    .vert_rd_addr(vert_rd_addr), .vert_rd_data(vert_rd_data), .tri_rd_addr(tri_rd_addr), .tri_rd_data(tri_rd_data),
    .inst_rd_req(inst_rd_req), .inst_rd_id(inst_rd_id), .inst_rd_valid(inst_rd_valid), .inst_rd_hit(inst_rd_hit),
    .inst_rd_transform(inst_rd_transform), .inst_rd_vert_base(inst_rd_vert_base), .inst_rd_vert_count(inst_rd_vert_count),
    .inst_rd_tri_base(inst_rd_tri_base), .inst_rd_tri_count(inst_rd_tri_count)
  );
  function automatic logic [383:0] rnd();
    logic [383:0] r = '0;
    for (int i = 0; i < 12; i++) r = {r[351:0], 32'($urandom())};
    return r;
  endfunction
  function automatic void m_wipe();
    for (int i = 0; i < 256; i++) begin
      m_val[i] = 1'b0;
      m_vb[i] = '0;
      m_vc[i] = '0;
      m_tb[i] = '0;
      m_tc[i] = '0;
    end
    m_cnt = 0;
  endfunction
  function automatic logic [428:0] m_lkp(input int id);
    if (!m_val[id]) return '0;
    return {1'b1, m_tr[id], m_vb[m_vid[id]], m_vc[m_vid[id]], m_tb[m_tid[id]], m_tc[m_tid[id]]};
  endfunction
  task automatic beat(input logic [3:0] op, input int id, input int base, input int cnt, input int vid, input int tid, input logic [383:0] d);
    int n = 0;
    cmd_op = op; cmd_id = 8'(id); cmd_base = 13'(base); cmd_count = 9'(cnt);
    cmd_vid = 8'(vid); cmd_tid = 8'(tid); cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    total++;
    if (n == 2000) begin bad++; $display("FAIL beat_wait: cmd_ready stayed %0b, required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask
  task automatic load_buf(input bit is_tri, input int id, input int base, input int cnt);
    logic [383:0] d;
    beat(is_tri ? 4'd2 : 4'd1, id, base, cnt, 0, 0, '0);
    if (is_tri) begin m_tb[id] = 13'(base); m_tc[id] = 9'(cnt); end
    else begin m_vb[id] = 13'(base); m_vc[id] = 9'(cnt); end
    for (int i = 0; i < cnt; i++) begin
      d = rnd();
      beat(4'($urandom_range(15)), 0, 0, 0, 0, 0, d);
      if (is_tri) m_tram[(base + i) % MT] = d[23:0]; else m_vram[(base + i) % MV] = d[107:0];
    end
  endtask
  task automatic create(input int id, input int vid, input int tid, input logic [383:0] t);
    beat(4'd3, id, 0, 0, vid, tid, t);
    if (!m_val[id]) m_cnt++;
    m_val[id] = 1'b1; m_tr[id] = t; m_vid[id] = 8'(vid); m_tid[id] = 8'(tid);
  endtask
  task automatic rd_vert(input int a, output logic [107:0] d);
    vert_rd_addr = 13'(a); @(posedge clk); #1; d = vert_rd_data;
  endtask
  task automatic rd_tri(input int a, output logic [23:0] d);
    tri_rd_addr = 13'(a); @(posedge clk); #1; d = tri_rd_data;
  endtask
  task automatic do_lookup(input int id, output logic [429:0] o);
    inst_rd_req = 1'b1; inst_rd_id = 8'(id);
    @(posedge clk); #1; inst_rd_req = 1'b0;
    @(posedge clk); #1;
    o = {inst_rd_valid, inst_rd_hit, inst_rd_transform, inst_rd_vert_base, inst_rd_vert_count, inst_rd_tri_base, inst_rd_tri_count};
  endtask
  task automatic test_reset();
    int n = 0;
    bit rdy = 1'b0;
    logic [429:0] o;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, cmd_ready, cmd_err, inst_count, inst_rd_valid, vert_rd_data, tri_rd_data} !== {1'b1, 144'b0}) begin
      bad++; $display("FAIL reset_outs: busy=%0b ready=%0b err=%0b cnt=%0d rv=%0b required busy=1 rest 0", busy, cmd_ready, cmd_err, inst_count, inst_rd_valid);
    end
    rst_n = 1'b1;
    while (busy && n < 1000) begin rdy |= cmd_ready; @(posedge clk); #1; n++; end
    m_wipe();
    total++;
    if (n != 256) begin bad++; $display("FAIL reset_wipe_len: busy cycles=%0d required 256", n); end
    total++;
    if (rdy) begin bad++; $display("FAIL reset_wipe_ready: cmd_ready=1 during wipe, required 0"); end
    total++;
    if ({cmd_ready, inst_count} !== {1'b1, 9'(m_cnt)}) begin bad++; $display("FAIL reset_idle: ready=%0b cnt=%0d required 1 %0d", cmd_ready, inst_count, m_cnt); end
    do_lookup(5, o);
    total++;
    if (o !== {1'b1, m_lkp(5)}) begin bad++; $display("FAIL reset_lookup5: got %h required %h", o, {1'b1, m_lkp(5)}); end
  endtask
  task automatic test_vert();
    logic [107:0] q;
    int id, base, cnt;
    beat(4'd1, 3, 100, 4, 0, 0, '0);
    m_vb[3] = 13'd100; m_vc[3] = 9'd4;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL vhdr_busy: busy=%0b required 1", busy); end
    for (int i = 0; i < 4; i++) begin
      beat(4'($urandom_range(15)), 0, 0, 0, 0, 0, 384'(32'hA + i));
      m_vram[100 + i] = 108'(32'hA + i);
      total++;
      if (busy !== 1'(i < 3)) begin bad++; $display("FAIL vdata_busy%0d: busy=%0b required %0b", i, busy, i < 3); end
    end
    for (int i = 0; i < 4; i++) begin
      rd_vert(100 + i, q);
      total++;
      if (q !== m_vram[100 + i]) begin bad++; $display("FAIL vread%0d: got %h required %h", 100 + i, q, m_vram[100 + i]); end
    end
    id = $urandom_range(40, 200); base = $urandom_range(200, 7000); cnt = $urandom_range(1, 12);
    load_buf(1'b0, id, base, cnt);
    for (int i = 0; i < cnt; i++) begin
      rd_vert(base + i, q);
      total++;
      if (q !== m_vram[base + i]) begin bad++; $display("FAIL vread_rnd%0d: got %h required %h", base + i, q, m_vram[base + i]); end
    end
  endtask
  task automatic test_inst();
    logic [23:0] q;
    logic [429:0] o;
    load_buf(1'b1, 2, 8, 2);
    for (int i = 0; i < 2; i++) begin
      rd_tri(8 + i, q);
      total++;
      if (q !== m_tram[8 + i]) begin bad++; $display("FAIL tread%0d: got %h required %h", 8 + i, q, m_tram[8 + i]); end
    end
    create(7, 3, 2, rnd());
    do_lookup(7, o);
    total++;
    if (o !== {1'b1, m_lkp(7)}) begin bad++; $display("FAIL lookup7: got %h required %h", o, {1'b1, m_lkp(7)}); end
    total++;
    if (inst_count !== 9'(m_cnt)) begin bad++; $display("FAIL count_create: got %0d required %0d", inst_count, m_cnt); end
    create(30, 3, 2, rnd());
    create(30, $urandom_range(40, 200), 2, rnd());
    for (int i = 0; i < 4; i++) create($urandom_range(12, 40), $urandom_range(0, 255), 2, rnd());
    total++;
    if (inst_count !== 9'(m_cnt)) begin bad++; $display("FAIL count_recreate: got %0d required %0d", inst_count, m_cnt); end
    do_lookup(30, o);
    total++;
    if (o !== {1'b1, m_lkp(30)}) begin bad++; $display("FAIL lookup30: got %h required %h", o, {1'b1, m_lkp(30)}); end
  endtask
  task automatic test_update_delete();
    logic [429:0] o;
    logic [383:0] t2 = rnd();
    beat(4'd4, 7, 0, 0, 99, 99, t2);
    if (m_val[7]) m_tr[7] = t2;
    total++;
    if (cmd_err !== 1'b0) begin bad++; $display("FAIL upd_valid_err: got %0b required 0", cmd_err); end
    do_lookup(7, o);
    total++;
    if (o !== {1'b1, m_lkp(7)}) begin bad++; $display("FAIL lookup_upd: got %h required %h", o, {1'b1, m_lkp(7)}); end
    beat(4'd5, 7, 0, 0, 0, 0, '0);
    if (m_val[7]) m_cnt--;
    m_val[7] = 1'b0;
    do_lookup(7, o);
    total++;
    if (o !== {1'b1, m_lkp(7)}) begin bad++; $display("FAIL lookup_del: got %h required %h", o, {1'b1, m_lkp(7)}); end
    total++;
    if (inst_count !== 9'(m_cnt)) begin bad++; $display("FAIL count_del: got %0d required %0d", inst_count, m_cnt); end
    beat(4'd4, 9, 0, 0, 0, 0, rnd());
    total++;
    if (cmd_err !== 1'b1) begin bad++; $display("FAIL upd_invalid_err: got %0b required 1", cmd_err); end
    @(posedge clk); #1;
    total++;
    if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %0b required 0", cmd_err); end
    beat(4'd5, 9, 0, 0, 0, 0, '0);
    total++;
    if ({cmd_err, inst_count} !== {1'b0, 9'(m_cnt)}) begin bad++; $display("FAIL del_invalid: err=%0b cnt=%0d required 0 %0d", cmd_err, inst_count, m_cnt); end
  endtask
  task automatic test_wrap();
    logic [107:0] q;
    logic [383:0] d;
    logic [429:0] o;
    int a;
    load_buf(1'b0, 4, 8188, 4);
    load_buf(1'b0, 5, 0, 2);
    beat(4'd1, 3, 8190, 4, 0, 0, '0);
`ifdef SCENE_MEM_BOUNDS_CHECK_EN
    total++;
    if (cmd_err !== 1'b1) begin bad++; $display("FAIL wrap_err: got %0b required 1", cmd_err); end
    for (int i = 0; i < 4; i++) beat(4'($urandom_range(15)), 0, 0, 0, 0, 0, rnd());
`else
    total++;
    if (cmd_err !== 1'b0) begin bad++; $display("FAIL wrap_err: got %0b required 0", cmd_err); end
    m_vb[3] = 13'd8190; m_vc[3] = 9'd4;
    for (int i = 0; i < 4; i++) begin
      d = rnd();
      beat(4'($urandom_range(15)), 0, 0, 0, 0, 0, d);
      m_vram[(8190 + i) % MV] = d[107:0];
    end
`endif
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy: got %0b required 0", busy); end
    for (int i = 0; i < 4; i++) begin
      a = (8190 + i) % MV;
      rd_vert(a, q);
      total++;
      if (q !== m_vram[a]) begin bad++; $display("FAIL wrap_read%0d: got %h required %h", a, q, m_vram[a]); end
    end
    create(11, 3, 2, rnd());
    do_lookup(11, o);
    total++;
    if (o !== {1'b1, m_lkp(11)}) begin bad++; $display("FAIL wrap_desc: got %h required %h", o, {1'b1, m_lkp(11)}); end
  endtask
  task automatic test_back_to_back();
    logic [429:0] q[$];
    logic [429:0] o, e;
    int id;
    for (int k = 0; k <= 40; k++) begin
      if (k < 40 && $urandom_range(3) != 0) begin
        id = $urandom_range(0, 40);
        inst_rd_req = 1'b1; inst_rd_id = 8'(id);
        q.push_back({1'b1, m_lkp(id)});
      end else begin
        inst_rd_req = 1'b0;
        if (k < 40) q.push_back('0);
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        e = q.pop_front();
        o = {inst_rd_valid, inst_rd_hit, inst_rd_transform, inst_rd_vert_base, inst_rd_vert_count, inst_rd_tri_base, inst_rd_tri_count};
        total++;
        if (o !== e) begin bad++; $display("FAIL b2b%0d: got %h required %h", k, o, e); end
      end
    end
    inst_rd_req = 1'b0;
  endtask
  task automatic test_wipe();
    logic [429:0] o;
    int n = 0;
    create(1, 3, 2, rnd());
    create(2, 5, 2, rnd());
    beat(4'd0, 0, 0, 0, 0, 0, '0);
    total++;
    if ({cmd_ready, busy, inst_count} !== {1'b0, 1'b1, 9'd0}) begin bad++; $display("FAIL wipe_entry: ready=%0b busy=%0b cnt=%0d required 0 1 0", cmd_ready, busy, inst_count); end
    while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
    m_wipe();
    total++;
    if (n != 256) begin bad++; $display("FAIL wipe_len: ready low %0d cycles, required 256", n); end
    for (int i = 1; i <= 2; i++) begin
      do_lookup(i, o);
      total++;
      if (o !== {1'b1, m_lkp(i)}) begin bad++; $display("FAIL wipe_lookup%0d: got %h required %h", i, o, {1'b1, m_lkp(i)}); end
    end
    create(1, 3, 2, rnd());
    do_lookup(1, o);
    total++;
    if (o !== {1'b1, m_lkp(1)}) begin bad++; $display("FAIL wipe_desc: got %h required %h", o, {1'b1, m_lkp(1)}); end
    beat(4'd12, 0, 0, 0, 0, 0, '0);
    total++;
    if ({cmd_err, busy, cmd_ready} !== 3'b101) begin bad++; $display("FAIL bad_op: err=%0b busy=%0b ready=%0b required 1 0 1", cmd_err, busy, cmd_ready); end
  endtask
  task automatic test_reset_mid();
    logic [107:0] q;
    logic [383:0] d;
    int n = 0;
    load_buf(1'b0, 6, 500, 4);
    beat(4'd1, 6, 500, 4, 0, 0, '0);
    for (int i = 0; i < 2; i++) begin
      d = rnd();
      beat(4'($urandom_range(15)), 0, 0, 0, 0, 0, d);
      m_vram[500 + i] = d[107:0];
    end
    cmd_data = rnd(); cmd_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, busy, inst_count} !== {1'b0, 1'b1, 9'd0}) begin bad++; $display("FAIL midreset_outs: ready=%0b busy=%0b cnt=%0d required 0 1 0", cmd_ready, busy, inst_count); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; cmd_valid = 1'b0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
    m_wipe();
    total++;
    if (n != 256) begin bad++; $display("FAIL midreset_wipe: busy %0d cycles, required 256", n); end
    for (int i = 0; i < 4; i++) begin
      rd_vert(500 + i, q);
      total++;
      if (q !== m_vram[500 + i]) begin bad++; $display("FAIL midreset_read%0d: got %h required %h", 500 + i, q, m_vram[500 + i]); end
    end
  endtask
  initial begin
    test_reset();
    test_vert();
    test_inst();
    test_update_delete();
    test_wrap();
    test_back_to_back();
    test_wipe();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
